// File: rtl/complex_multi_pipe.sv
// Pipelined fixed-point complex multiplier (optionally conjugating operand 1) with
// rounding, saturation/wrap, overflow flag and a valid/ready stream handshake.
module complex_multi_pipe #(
  parameter int DATA_W     = 32,
  parameter int FRAC_W     = 8,
  parameter int ROUND_MODE = 0,
  parameter int SATURATE   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_conj,
  input  logic signed [DATA_W-1:0] in_0_real,
  input  logic signed [DATA_W-1:0] in_0_imag,
  input  logic signed [DATA_W-1:0] in_1_real,
  input  logic signed [DATA_W-1:0] in_1_imag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_real,
  output logic signed [DATA_W-1:0] out_imag,
  output logic                     out_ovf
);

  localparam int PW = 2 * DATA_W;
  localparam int SW = 2 * DATA_W + 1;
  localparam logic [SW-1:0] RND_ADD = (ROUND_MODE != 0) ? (SW'(1) << (FRAC_W - 1)) : '0;
  localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  logic                     s1_valid, s1_conj;
  logic signed [DATA_W-1:0] s1_ar, s1_ai, s1_br, s1_bi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_conj  <= 1'b0;
      s1_ar    <= '0;
      s1_ai    <= '0;
      s1_br    <= '0;
      s1_bi    <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_conj <= in_conj;
        s1_ar   <= in_0_real;
        s1_ai   <= in_0_imag;
        s1_br   <= in_1_real;
        s1_bi   <= in_1_imag;
      end
    end
  end

  // Operands are sign-extended so the full-width products are exact.
  logic signed [PW-1:0] ar_x, ai_x, br_x, bi_x;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  assign ar_x = {{DATA_W{s1_ar[DATA_W-1]}}, s1_ar};
  assign ai_x = {{DATA_W{s1_ai[DATA_W-1]}}, s1_ai};
  assign br_x = {{DATA_W{s1_br[DATA_W-1]}}, s1_br};
  assign bi_x = {{DATA_W{s1_bi[DATA_W-1]}}, s1_bi};
  assign p_rr = ar_x * br_x;
  assign p_ii = ai_x * bi_x;
  assign p_ri = ar_x * bi_x;
  assign p_ir = ai_x * br_x;

  logic                 s2_valid;
  logic signed [PW-1:0] s2_rr, s2_ii, s2_ri, s2_ir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_rr    <= '0;
      s2_ii    <= '0;
      s2_ri    <= '0;
      s2_ir    <= '0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_rr <= p_rr;
        s2_ii <= s1_conj ? -p_ii : p_ii;
        s2_ri <= s1_conj ? -p_ri : p_ri;
        s2_ir <= p_ir;
      end
    end
  end

  // One guard bit above the products keeps the sums exact before rounding.
  logic signed [SW-1:0] re_sum, im_sum;
  assign re_sum = {s2_rr[PW-1], s2_rr} - {s2_ii[PW-1], s2_ii} + RND_ADD;
  assign im_sum = {s2_ri[PW-1], s2_ri} + {s2_ir[PW-1], s2_ir} + RND_ADD;

  logic                 s3_valid;
  logic signed [SW-1:0] s3_re, s3_im;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid <= 1'b0;
      s3_re    <= '0;
      s3_im    <= '0;
    end else if (!stall) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_re <= re_sum >>> FRAC_W;
        s3_im <= im_sum >>> FRAC_W;
      end
    end
  end

  // In range exactly when every bit from the result sign bit upward agrees.
  logic              re_ovf, im_ovf;
  logic [DATA_W-1:0] re_res, im_res;
  assign re_ovf = !((&s3_re[SW-1:DATA_W-1]) || !(|s3_re[SW-1:DATA_W-1]));
  assign im_ovf = !((&s3_im[SW-1:DATA_W-1]) || !(|s3_im[SW-1:DATA_W-1]));
  assign re_res = (SATURATE != 0 && re_ovf) ? (s3_re[SW-1] ? MIN_V : MAX_V) : s3_re[DATA_W-1:0];
  assign im_res = (SATURATE != 0 && im_ovf) ? (s3_im[SW-1] ? MIN_V : MAX_V) : s3_im[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      out_ovf   <= 1'b0;
    end else if (!stall) begin
      out_valid <= s3_valid;
      if (s3_valid) begin
        out_real <= re_res;
        out_imag <= im_res;
        out_ovf  <= re_ovf || im_ovf;
      end
    end
  end

endmodule

// File: tb/tb_complex_multi_pipe.sv
// Directed and scoreboard bench for complex_multi_pipe; three instances cover
// truncate+saturate, round+saturate and truncate+wrap on shared stimulus.
module tb_complex_multi_pipe;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_conj, out_ready;
  logic [31:0] a_r, a_i, b_r, b_i;
  logic [2:0]  in_rdy, o_valid, o_ovf;
  logic [31:0] o_re [3];
  logic [31:0] o_im [3];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0][31:0] re;
    logic [2:0][31:0] im;
    logic [2:0]       ovf;
    int               t;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  complex_multi_pipe #(.DATA_W(32), .FRAC_W(8), .ROUND_MODE(0), .SATURATE(1)) dut_trunc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[0]), .in_conj(in_conj),
    .in_0_real(a_r), .in_0_imag(a_i), .in_1_real(b_r), .in_1_imag(b_i),
    .out_valid(o_valid[0]), .out_ready(out_ready), .out_real(o_re[0]), .out_imag(o_im[0]),
    .out_ovf(o_ovf[0]));

  complex_multi_pipe #(.DATA_W(32), .FRAC_W(8), .ROUND_MODE(1), .SATURATE(1)) dut_round (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[1]), .in_conj(in_conj),
    .in_0_real(a_r), .in_0_imag(a_i), .in_1_real(b_r), .in_1_imag(b_i),
    .out_valid(o_valid[1]), .out_ready(out_ready), .out_real(o_re[1]), .out_imag(o_im[1]),
    .out_ovf(o_ovf[1]));

  complex_multi_pipe #(.DATA_W(32), .FRAC_W(8), .ROUND_MODE(0), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[2]), .in_conj(in_conj),
    .in_0_real(a_r), .in_0_imag(a_i), .in_1_real(b_r), .in_1_imag(b_i),
    .out_valid(o_valid[2]), .out_ready(out_ready), .out_real(o_re[2]), .out_imag(o_im[2]),
    .out_ovf(o_ovf[2]));

  // Reference applies the conjugate to the operand rather than to the products.
  function automatic logic [64:0] golden(input logic [31:0] ar, ai, br, bi,
                                         input logic cj, input bit rnd, input bit sat);
    logic signed [66:0] xr, xi, yr, yi, re, im;
    logic [31:0] ore, oim;
    logic ovr, ovi;
    xr = {{35{ar[31]}}, ar};
    xi = {{35{ai[31]}}, ai};
    yr = {{35{br[31]}}, br};
    yi = {{35{bi[31]}}, bi};
    if (cj) yi = -yi;
    re = xr * yr - xi * yi;
    im = xr * yi + xi * yr;
    if (rnd) begin
      re = re + 67'sd128;
      im = im + 67'sd128;
    end
    re = re >>> 8;
    im = im >>> 8;
    ovr = (re > 67'sd2147483647) || (re < -67'sd2147483648);
    ovi = (im > 67'sd2147483647) || (im < -67'sd2147483648);
    ore = (sat && ovr) ? (re[66] ? 32'h80000000 : 32'h7FFFFFFF) : re[31:0];
    oim = (sat && ovi) ? (im[66] ? 32'h80000000 : 32'h7FFFFFFF) : im[31:0];
    return {ovr | ovi, oim, ore};
  endfunction

  function automatic exp_t predict(input int t);
    exp_t e;
    logic [64:0] g;
    for (int d = 0; d < 3; d++) begin
      g = golden(a_r, a_i, b_r, b_i, in_conj, d == 1, d != 2);
      e.re[d]  = g[31:0];
      e.im[d]  = g[63:32];
      e.ovf[d] = g[64];
    end
    e.t = t;
    return e;
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    v = $urandom();
    case ($urandom_range(0, 2))
      0: v = {{16{v[15]}}, v[15:0]};
      1: v = {{8{v[23]}}, v[23:0]};
      default: ;
    endcase
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ar, ai, br, bi, input logic cj);
    in_valid = 1'b1;
    a_r = ar;
    a_i = ai;
    b_r = br;
    b_i = bi;
    in_conj = cj;
  endtask

  task automatic drive_random();
    drive(rnd_op(), rnd_op(), rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
  endtask

  task automatic run_one(input logic [31:0] ar, ai, br, bi, input logic cj);
    drive(ar, ai, br, bi, cj);
    cyc();
    in_valid = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({o_valid[d], in_rdy[d], o_re[d], o_im[d], o_ovf[d]} !== {1'b0, 1'b1, 32'h0, 32'h0, 1'b0}) begin
        errors++;
        $display("[TB] FAIL reset dut%0d got v=%b rdy=%b re=%h im=%h ovf=%b exp v=0 rdy=1 re=0 im=0 ovf=0",
                 d, o_valid[d], in_rdy[d], o_re[d], o_im[d], o_ovf[d]);
      end
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    drive(32'd256, 32'd256, 32'd512, 32'd0, 1'b0);
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    checks++;
    if (o_valid !== 3'b000) begin
      errors++;
      $display("[TB] FAIL latency_early got out_valid=%b exp 000", o_valid);
    end
    cyc();
    checks++;
    if (o_valid !== 3'b111) begin
      errors++;
      $display("[TB] FAIL latency got out_valid=%b exp 111", o_valid);
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({o_re[d], o_im[d], o_ovf[d]} !== {32'd512, 32'd512, 1'b0}) begin
        errors++;
        $display("[TB] FAIL basic dut%0d got re=%h im=%h ovf=%b exp re=200 im=200 ovf=0",
                 d, o_re[d], o_im[d], o_ovf[d]);
      end
    end
    cyc();
    run_one(32'd256, 32'd256, 32'd0, 32'd256, 1'b1);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({o_valid[d], o_re[d], o_im[d], o_ovf[d]} !== {1'b1, 32'd256, 32'hFFFFFF00, 1'b0}) begin
        errors++;
        $display("[TB] FAIL conj dut%0d got v=%b re=%h im=%h ovf=%b exp v=1 re=100 im=ffffff00 ovf=0",
                 d, o_valid[d], o_re[d], o_im[d], o_ovf[d]);
      end
    end
    cyc();
  endtask

  task automatic test_round();
    logic [31:0] v [2][4] = '{'{32'd1, 32'd0, 32'd128, 32'd0}, '{32'hFFFFFFFF, 32'd0, 32'd128, 32'd0}};
    logic [31:0] er [2][3] = '{'{32'd0, 32'd1, 32'd0}, '{32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF}};
    for (int n = 0; n < 2; n++) begin
      run_one(v[n][0], v[n][1], v[n][2], v[n][3], 1'b0);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if ({o_valid[d], o_re[d], o_im[d], o_ovf[d]} !== {1'b1, er[n][d], 32'd0, 1'b0}) begin
          errors++;
          $display("[TB] FAIL round vec%0d dut%0d got v=%b re=%h im=%h ovf=%b exp v=1 re=%h im=0 ovf=0",
                   n, d, o_valid[d], o_re[d], o_im[d], o_ovf[d], er[n][d]);
        end
      end
      cyc();
    end
  endtask

  task automatic test_saturate();
    logic [31:0] v [5][4] = '{
      '{32'h7FFFFFFF, 32'd0, 32'h7FFFFFFF, 32'd0},
      '{32'h7FFFFFFF, 32'd0, 32'h80000001, 32'd0},
      '{32'h7FFFFFFF, 32'd0, 32'd256, 32'd0},
      '{32'h80000000, 32'd0, 32'd256, 32'd0},
      '{32'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'd0}};
    logic [31:0] er [5][3] = '{
      '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFF000000},
      '{32'h80000000, 32'h80000000, 32'h00FFFFFF},
      '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF},
      '{32'h80000000, 32'h80000000, 32'h80000000},
      '{32'd0, 32'd0, 32'd0}};
    logic [31:0] ei [5][3] = '{
      '{32'd0, 32'd0, 32'd0}, '{32'd0, 32'd0, 32'd0}, '{32'd0, 32'd0, 32'd0},
      '{32'd0, 32'd0, 32'd0}, '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFF000000}};
    logic [2:0] eo [5] = '{3'b111, 3'b111, 3'b000, 3'b000, 3'b111};
    for (int n = 0; n < 5; n++) begin
      run_one(v[n][0], v[n][1], v[n][2], v[n][3], 1'b0);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if ({o_valid[d], o_re[d], o_im[d], o_ovf[d]} !== {1'b1, er[n][d], ei[n][d], eo[n][d]}) begin
          errors++;
          $display("[TB] FAIL sat vec%0d dut%0d got v=%b re=%h im=%h ovf=%b exp v=1 re=%h im=%h ovf=%b",
                   n, d, o_valid[d], o_re[d], o_im[d], o_ovf[d], er[n][d], ei[n][d], eo[n][d]);
        end
      end
      cyc();
    end
  endtask

  task automatic test_stream();
    exp_t e;
    int got = 0;
    sb.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (c < 20) drive_random();
      else in_valid = 1'b0;
      @(negedge clk);
      if (in_valid && in_rdy[0]) sb.push_back(predict(c));
      if (o_valid[0]) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL stream_extra got unexpected output at iter %0d exp none", c);
        end else begin
          e = sb.pop_front();
          got++;
          checks++;
          if (c - e.t != 4) begin
            errors++;
            $display("[TB] FAIL stream_latency got %0d iterations exp 4", c - e.t);
          end
          for (int d = 0; d < 3; d++) begin
            checks++;
            if ({o_re[d], o_im[d], o_ovf[d]} !== {e.re[d], e.im[d], e.ovf[d]}) begin
              errors++;
              $display("[TB] FAIL stream dut%0d got re=%h im=%h ovf=%b exp re=%h im=%h ovf=%b",
                       d, o_re[d], o_im[d], o_ovf[d], e.re[d], e.im[d], e.ovf[d]);
            end
          end
        end
      end
      cyc();
    end
    checks++;
    if (got != 20 || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL stream_count got %0d outputs (%0d pending) exp 20 (0 pending)", got, sb.size());
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int got = 0;
    bit seen = 1'b0;
    sb.delete();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_random();
      @(negedge clk);
      if (in_valid && in_rdy[0]) sb.push_back(predict(k));
      cyc();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (o_valid[0]) seen = 1'b1;
      else cyc();
    end
    checks++;
    if (!seen || sb.size() != 3) begin
      errors++;
      $display("[TB] FAIL bp_fill got seen=%0d queued=%0d exp seen=1 queued=3", seen, sb.size());
    end
    for (int k = 0; k < 5; k++) begin
      cyc();
      e = sb[0];
      for (int d = 0; d < 3; d++) begin
        checks++;
        if ({in_rdy[d], o_valid[d], o_re[d], o_im[d], o_ovf[d]} !== {1'b0, 1'b1, e.re[d], e.im[d], e.ovf[d]}) begin
          errors++;
          $display("[TB] FAIL bp_stall cyc%0d dut%0d got rdy=%b v=%b re=%h im=%h ovf=%b exp rdy=0 v=1 re=%h im=%h ovf=%b",
                   k, d, in_rdy[d], o_valid[d], o_re[d], o_im[d], o_ovf[d], e.re[d], e.im[d], e.ovf[d]);
        end
      end
    end
    out_ready = 1'b1;
    // Release phase, then a long run with random valid/ready on both sides.
    for (int c = 0; c < 520; c++) begin
      if (c >= 10 && c < 510) begin
        if ($urandom_range(0, 3) != 0) drive_random();
        else in_valid = 1'b0;
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (in_valid && in_rdy[0]) sb.push_back(predict(c));
      if (o_valid[0] && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL bp_extra got unexpected output at iter %0d exp none", c);
        end else begin
          e = sb.pop_front();
          if (c < 10) got++;
          for (int d = 0; d < 3; d++) begin
            checks++;
            if ({o_re[d], o_im[d], o_ovf[d]} !== {e.re[d], e.im[d], e.ovf[d]}) begin
              errors++;
              $display("[TB] FAIL bp_data iter%0d dut%0d got re=%h im=%h ovf=%b exp re=%h im=%h ovf=%b",
                       c, d, o_re[d], o_im[d], o_ovf[d], e.re[d], e.im[d], e.ovf[d]);
            end
          end
        end
      end
      cyc();
      if (c == 9) begin
        checks++;
        if (got != 3 || sb.size() != 0) begin
          errors++;
          $display("[TB] FAIL bp_release got %0d delivered (%0d pending) exp 3 (0 pending)", got, sb.size());
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL bp_drain got %0d pending exp 0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    sb.delete();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive_random();
      cyc();
    end
    out_ready = 1'b0;
    cyc();
    cyc();
    checks++;
    if (o_valid !== 3'b111 || in_rdy !== 3'b000) begin
      errors++;
      $display("[TB] FAIL pre_reset_stall got v=%b rdy=%b exp v=111 rdy=000", o_valid, in_rdy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({o_valid[d], in_rdy[d], o_re[d], o_im[d], o_ovf[d]} !== {1'b0, 1'b1, 32'h0, 32'h0, 1'b0}) begin
        errors++;
        $display("[TB] FAIL async_reset dut%0d got v=%b rdy=%b re=%h im=%h ovf=%b exp v=0 rdy=1 re=0 im=0 ovf=0",
                 d, o_valid[d], in_rdy[d], o_re[d], o_im[d], o_ovf[d]);
      end
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      checks++;
      if (o_valid !== 3'b000 || in_rdy !== 3'b111) begin
        errors++;
        $display("[TB] FAIL stale_after_reset cyc%0d got v=%b rdy=%b exp v=000 rdy=111", k, o_valid, in_rdy);
      end
    end
    out_ready = 1'b1;
    cyc();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_conj = 1'b0;
    out_ready = 1'b1;
    a_r = '0;
    a_i = '0;
    b_r = '0;
    b_i = '0;
    test_reset();
    test_basic();
    test_round();
    test_saturate();
    test_stream();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
